bitty_pc_unit: RTL and testbench
================================

Name: bitty_pc_unit

Overview:
Registered program-counter and control-flow unit for the bitty core. It replaces the purely combinational next-PC logic with a clocked PC and parametrised address and data widths. It adds unconditional jump, call/return through a hardware return-address stack, and a halt state. The unit sits between instruction fetch and the ALU result register and advances once per accepted `step`.

Parameters:
- ADDR_W, 8, PC width in bits; must be 1..INSTR_W-4. Also the width of the target field instruction[4 +: ADDR_W].
- DATA_W, 16, width of last_alu_result.
- INSTR_W, 16, instruction width.
- STACK_DEPTH, 4, number of return-address stack entries; must be >= 1.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- step  input  1  advance enable; the PC updates only on cycles where step=1.
- instruction  input  INSTR_W  instruction currently at pc.
- last_alu_result  input  DATA_W  most recent ALU/compare result.
- pc  output  ADDR_W  current program counter, registered.
- branch_taken  output  1  one-cycle registered pulse when the last step redirected the PC.
- halted  output  1  high while in HALT.
- stack_level  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_ovf  output  1  sticky: a call was attempted with the stack full.
- stack_unf  output  1  sticky: a return was attempted with the stack empty.

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC; branch_taken=0; halted=0; stack_level=0; stack_ovf=0; stack_unf=0; state=RUN.
  - Reset overrides step in the same cycle and aborts any operation in progress; stack contents are don't-care.
- Field decode:
  - fmt=instruction[1:0]; sub=instruction[3:2]; tgt=instruction[4 +: ADDR_W].
  - seq = pc+1, modulo 2^ADDR_W: the top address wraps to 0.
- Two states, RUN and HALT.
- In RUN with step=1, the next pc is chosen as follows:
  - fmt=10, sub=00: tgt if last_alu_result==0, else seq.
  - fmt=10, sub=01: tgt if last_alu_result==1, else seq.
  - fmt=10, sub=10: tgt if last_alu_result==2, else seq.
  - fmt=10, sub=11: seq (reserved).
  - Comparisons use the full DATA_W value; the constants are zero-extended.
  - fmt=11, sub=00 (CALL): if stack_level<STACK_DEPTH, push seq, stack_level+1, pc=tgt. If full: no push, pc=seq, stack_ovf<=1.
  - fmt=11, sub=01 (RET): if stack_level>0, pc=top entry, stack_level-1. If empty: pc=seq, stack_unf<=1.
  - fmt=11, sub=10 (JMP): pc=tgt unconditionally.
  - fmt=11, sub=11 (HALT): pc unchanged, go to HALT, halted<=1.
  - fmt=00 or 01: pc=seq.
- branch_taken:
  - Set to 1 for exactly the cycle after a step whose result came from tgt or from a successful RET.
  - Set to 0 after any other step and on every non-step cycle.
  - A taken redirect is flagged even when tgt==seq.
- RUN with step=0: all state holds; branch_taken=0.
- HALT:
  - pc, stack and flags hold; step and instruction are ignored; branch_taken=0.
  - Only reset leaves HALT.
- Stack:
  - LIFO; push and pop never happen in the same cycle.
  - Entries are ADDR_W wide.
  - The sticky flags clear only on reset.
- Latency:
  - pc and all outputs are registered; the next-PC decision is visible one clock after the step edge.
  - No combinational path from any input to any output.

Test Plan:
- Reset then 3 steps with instruction=0x0000 -> pc 0,1,2,3; branch_taken stays 0; stack_level=0.
- Conditional branches:
  - pc=5, instruction=0x0402 (fmt 10, sub 00, tgt 0x40), last_alu_result=0, step -> pc=0x40, branch_taken=1 for one cycle.
  - Same instruction with last_alu_result=0x0100 -> pc=6, branch_taken=0.
- Call and return: at pc=0x10, CALL tgt 0x80 (instruction 0x0803) -> pc=0x80, stack_level=1. Then RET (0x0007) -> pc=0x11, stack_level=0, branch_taken pulses both times.
- Stack overflow, STACK_DEPTH=4:
  - 5 consecutive CALLs -> the fifth gives pc=prev+1, stack_ovf=1, stack_level=4.
  - 4 RETs then return the addresses in LIFO order.
  - A fifth RET -> pc=seq, stack_unf=1.
- Wrap and stall: at pc=0xFF (ADDR_W=8), step with fmt 00 -> pc=0x00. Holding step=0 for 3 cycles with a JMP instruction present -> pc unchanged.
- Halt and reset:
  - HALT (0x000F) at pc=0x20 -> halted=1; pc stays 0x20 for 10 steps with varied instructions.
  - Reset asserted together with step and a JMP -> pc=RESET_PC, halted=0, stack_ovf=0, stack_unf=0.

Source files
------------

// File: rtl/bitty_pc_unit.sv
// bitty_pc_unit: registered program counter and control-flow unit.
//
// Advances the PC once per accepted step. Supports sequential flow,
// conditional branches on the last ALU result, an unconditional jump,
// call/return through a small hardware return-address stack, and a halt
// state that only reset leaves.
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous active-high reset
//   step            advance enable
//   instruction     instruction at pc (fmt[1:0], sub[3:2], tgt[4 +: ADDR_W])
//   last_alu_result most recent ALU/compare result
//   pc              current program counter (registered)
//   branch_taken    one-cycle pulse after a step that redirected the PC
//   halted          high while in HALT
//   stack_level     number of valid return-address entries
//   stack_ovf       sticky: CALL attempted with stack full
//   stack_unf       sticky: RET attempted with stack empty
module bitty_pc_unit #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int INSTR_W     = 16,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               step,
    input  logic [INSTR_W-1:0]                 instruction,
    input  logic [DATA_W-1:0]                  last_alu_result,
    output logic [ADDR_W-1:0]                  pc,
    output logic                               branch_taken,
    output logic                               halted,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    localparam int LVL_W = $clog2(STACK_DEPTH+1);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(STACK_DEPTH);

    typedef enum logic { RUN = 1'b0, HALT = 1'b1 } state_t;

    state_t state_q, state_d;

    logic [1:0]        fmt, sub;
    logic [ADDR_W-1:0] tgt, seq, top, pc_d;
    logic [LVL_W-1:0]  level_d;
    logic              taken_d, ovf_d, unf_d, push, cond;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    assign fmt = instruction[1:0];
    assign sub = instruction[3:2];
    assign tgt = instruction[4 +: ADDR_W];
    assign seq = pc + ADDR_W'(1);

    // Instruction bits above the target field carry no meaning here.
    generate
        if (4 + ADDR_W < INSTR_W) begin : g_unused
            logic unused_instr_hi;
            assign unused_instr_hi = ^instruction[INSTR_W-1:4+ADDR_W];
        end
    endgenerate

    // Top-of-stack entry sits at index stack_level-1.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (LVL_W'(i + 1) == stack_level) top = stack_mem[i];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        taken_d = 1'b0;
        level_d = stack_level;
        ovf_d   = stack_ovf;
        unf_d   = stack_unf;
        push    = 1'b0;
        cond    = 1'b0;
        if (state_q == RUN && step) begin
            case (fmt)
                2'b10: begin
                    case (sub)
                        2'b00:   cond = (last_alu_result == DATA_W'(0));
                        2'b01:   cond = (last_alu_result == DATA_W'(1));
                        2'b10:   cond = (last_alu_result == DATA_W'(2));
                        default: cond = 1'b0;
                    endcase
                    pc_d    = cond ? tgt : seq;
                    taken_d = cond;
                end
                2'b11: begin
                    case (sub)
                        2'b00: begin
                            if (stack_level != DEPTH_L) begin
                                push    = 1'b1;
                                level_d = stack_level + LVL_W'(1);
                                pc_d    = tgt;
                                taken_d = 1'b1;
                            end else begin
                                pc_d  = seq;
                                ovf_d = 1'b1;
                            end
                        end
                        2'b01: begin
                            if (stack_level != '0) begin
                                pc_d    = top;
                                level_d = stack_level - LVL_W'(1);
                                taken_d = 1'b1;
                            end else begin
                                pc_d  = seq;
                                unf_d = 1'b1;
                            end
                        end
                        2'b10: begin
                            pc_d    = tgt;
                            taken_d = 1'b1;
                        end
                        default: state_d = HALT;
                    endcase
                end
                default: pc_d = seq;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            pc           <= ADDR_W'(RESET_PC);
            branch_taken <= 1'b0;
            stack_level  <= '0;
            stack_ovf    <= 1'b0;
            stack_unf    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc           <= pc_d;
            branch_taken <= taken_d;
            stack_level  <= level_d;
            stack_ovf    <= ovf_d;
            stack_unf    <= unf_d;
        end
    end

    // Stack storage needs no reset; only entries below stack_level are read.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (LVL_W'(i) == stack_level) stack_mem[i] <= seq;
            end
        end
    end

    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_bitty_pc_unit.sv
// Testbench for bitty_pc_unit: directed vectors, scoreboard queue of
// expected post-edge outputs, independent monitor popping one entry per cycle.
module tb_bitty_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        step = 1'b0;
    logic [15:0] instruction = '0;
    logic [15:0] last_alu_result = '0;
    logic [7:0]  pc;
    logic        branch_taken, halted, stack_ovf, stack_unf;
    logic [2:0]  stack_level;

    bitty_pc_unit dut (
        .clk(clk), .reset(reset), .step(step), .instruction(instruction),
        .last_alu_result(last_alu_result), .pc(pc), .branch_taken(branch_taken),
        .halted(halted), .stack_level(stack_level), .stack_ovf(stack_ovf),
        .stack_unf(stack_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic       bt;
        logic       h;
        logic [2:0] lvl;
        logic       o;
        logic       u;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   stim_done = 0;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic t(input logic r, input logic s, input logic [15:0] ins,
                     input logic [15:0] alu, input logic [7:0] e_pc,
                     input logic e_bt, input logic e_h, input logic [2:0] e_lvl,
                     input logic e_o, input logic e_u, input string nm);
        exp_t e;
        @(negedge clk);
        reset = r; step = s; instruction = ins; last_alu_result = alu;
        e.pc = e_pc; e.bt = e_bt; e.h = e_h; e.lvl = e_lvl; e.o = e_o; e.u = e_u;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a registered result every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (pc === e.pc && branch_taken === e.bt && halted === e.h &&
                    stack_level === e.lvl && stack_ovf === e.o && stack_unf === e.u)
                    n_pass++;
                else
                    $display("FAIL %s: got pc=%h bt=%b h=%b lvl=%0d ovf=%b unf=%b, want pc=%h bt=%b h=%b lvl=%0d ovf=%b unf=%b",
                             e.name, pc, branch_taken, halted, stack_level, stack_ovf, stack_unf,
                             e.pc, e.bt, e.h, e.lvl, e.o, e.u);
            end
        end
    end

    logic [15:0] halt_ins [10] = '{16'h055B, 16'h0803, 16'h0007, 16'h0402, 16'h0000,
                                   16'h0406, 16'h000F, 16'h0301, 16'hFFFF, 16'h050A};

    initial begin
        // reset and sequential flow
        t(1, 0, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 0, 0, "reset");
        t(0, 1, 16'h0000, 16'h0000, 8'h01, 0, 0, 0, 0, 0, "seq1");
        t(0, 1, 16'h0000, 16'h0000, 8'h02, 0, 0, 0, 0, 0, "seq2");
        t(0, 1, 16'h0000, 16'h0000, 8'h03, 0, 0, 0, 0, 0, "seq3");
        // conditional branches
        t(0, 1, 16'h005B, 16'h0000, 8'h05, 1, 0, 0, 0, 0, "jmp5");
        t(0, 1, 16'h0402, 16'h0000, 8'h40, 1, 0, 0, 0, 0, "beq0_taken");
        t(0, 0, 16'h0402, 16'h0000, 8'h40, 0, 0, 0, 0, 0, "bt_pulse_end");
        t(0, 1, 16'h005B, 16'h0000, 8'h05, 1, 0, 0, 0, 0, "jmp5b");
        t(0, 1, 16'h0402, 16'h0100, 8'h06, 0, 0, 0, 0, 0, "beq0_fullwidth");
        t(0, 1, 16'h0406, 16'h0001, 8'h40, 1, 0, 0, 0, 0, "beq1_taken");
        t(0, 1, 16'h050A, 16'h0002, 8'h50, 1, 0, 0, 0, 0, "beq2_taken");
        t(0, 1, 16'h050A, 16'h0102, 8'h51, 0, 0, 0, 0, 0, "beq2_not");
        t(0, 1, 16'h060E, 16'h0000, 8'h52, 0, 0, 0, 0, 0, "reserved_sub");
        t(0, 1, 16'h0301, 16'h0000, 8'h53, 0, 0, 0, 0, 0, "fmt01");
        t(0, 1, 16'h054B, 16'h0000, 8'h54, 1, 0, 0, 0, 0, "jmp_tgt_eq_seq");
        // call / return
        t(0, 1, 16'h010B, 16'h0000, 8'h10, 1, 0, 0, 0, 0, "jmp10");
        t(0, 1, 16'h0803, 16'h0000, 8'h80, 1, 0, 1, 0, 0, "call80");
        t(0, 1, 16'h0007, 16'h0000, 8'h11, 1, 0, 0, 0, 0, "ret11");
        // overflow then LIFO unwind then underflow
        t(0, 1, 16'h0203, 16'h0000, 8'h20, 1, 0, 1, 0, 0, "call1");
        t(0, 1, 16'h0303, 16'h0000, 8'h30, 1, 0, 2, 0, 0, "call2");
        t(0, 1, 16'h0403, 16'h0000, 8'h40, 1, 0, 3, 0, 0, "call3");
        t(0, 1, 16'h0503, 16'h0000, 8'h50, 1, 0, 4, 0, 0, "call4");
        t(0, 1, 16'h0603, 16'h0000, 8'h51, 0, 0, 4, 1, 0, "call5_ovf");
        t(0, 1, 16'h0007, 16'h0000, 8'h41, 1, 0, 3, 1, 0, "ret4");
        t(0, 1, 16'h0007, 16'h0000, 8'h31, 1, 0, 2, 1, 0, "ret3");
        t(0, 1, 16'h0007, 16'h0000, 8'h21, 1, 0, 1, 1, 0, "ret2");
        t(0, 1, 16'h0007, 16'h0000, 8'h12, 1, 0, 0, 1, 0, "ret1");
        t(0, 1, 16'h0007, 16'h0000, 8'h13, 0, 0, 0, 1, 1, "ret_unf");
        // wrap and stall
        t(0, 1, 16'h0FFB, 16'h0000, 8'hFF, 1, 0, 0, 1, 1, "jmpFF");
        t(0, 1, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 1, 1, "wrap");
        for (int i = 0; i < 3; i++)
            t(0, 0, 16'h077B, 16'h0000, 8'h00, 0, 0, 0, 1, 1, "stall");
        // halt
        t(0, 1, 16'h020B, 16'h0000, 8'h20, 1, 0, 0, 1, 1, "jmp20");
        t(0, 1, 16'h000F, 16'h0000, 8'h20, 0, 1, 0, 1, 1, "halt");
        for (int i = 0; i < 10; i++)
            t(0, 1, halt_ins[i], 16'h0000, 8'h20, 0, 1, 0, 1, 1, "halted_hold");
        // reset beats step
        t(1, 1, 16'h055B, 16'h0000, 8'h00, 0, 0, 0, 0, 0, "reset_over_step");
        t(0, 1, 16'h0000, 16'h0000, 8'h01, 0, 0, 0, 0, 0, "run_after_reset");
        t(0, 0, 16'h0000, 16'h0000, 8'h01, 0, 0, 0, 0, 0, "idle");
        stim_done = 1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
